// File: rtl/serial_alu_slt.sv
// -----------------------------------------------------------------------------
// serial_alu_slt
//
// Bit-serial ALU. Walks one 1-bit ALU slice across a WIDTH-bit operand pair,
// LSB to MSB, one bit per clock. At the MSB it captures the slice's set, carry
// out and overflow. It then writes the signed less-than value back into
// result[0] for SLT. Operands and control are latched when a start is
// accepted, so the inputs may change freely while an operation runs.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any operation)
//   start        request a new operation, sampled only while idle
//   src1, src2   operands A and B (WIDTH bits)
//   ALU_control  [3] A_invert, [2] B_invert, [1:0] op: 00 AND 01 OR 10 ADD 11 SLT
//   result       operation result, held until the next accepted start
//   zero         result == 0
//   cout         carry out of the MSB (arithmetic ops only, else 0)
//   overflow     signed overflow (arithmetic ops only, else 0)
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse; result and flags are valid from then on
// -----------------------------------------------------------------------------
module serial_alu_slt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched operation
    logic [WIDTH-1:0] src1_q, src2_q;
    logic [3:0]       ctrl_q;

    // Serial datapath state
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;

    // Values captured at the MSB slice
    logic             set_q;
    logic             ovf_cap_q;
    logic             cout_cap_q;

    // Output flags
    logic             zero_q;
    logic             cout_q;
    logic             overflow_q;

    // Single 1-bit slice evaluated at the current bit index
    logic             a_bit, b_bit, sum_bit, carry_out, res_bit;
    logic             arith_op;
    logic [WIDTH-1:0] fixed_result;

    always_comb begin
        a_bit     = src1_q[idx_q] ^ ctrl_q[3];
        b_bit     = src2_q[idx_q] ^ ctrl_q[2];
        sum_bit   = a_bit ^ b_bit ^ carry_q;
        carry_out = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        res_bit   = 1'b0;
        case (ctrl_q[1:0])
            2'b00:   res_bit = a_bit & b_bit;
            2'b01:   res_bit = a_bit | b_bit;
            2'b10:   res_bit = sum_bit;
            default: res_bit = 1'b0;   // SLT: upper bits are zero, bit 0 fixed later
        endcase
    end

    // ADD and SLT both run the adder; only they report cout/overflow.
    assign arith_op = ctrl_q[1];

    // Final result as it will stand after the fix-up cycle. For SLT the sign
    // of the difference corrected by overflow gives the signed less-than.
    always_comb begin
        fixed_result = result_q;
        if (ctrl_q[1:0] == 2'b11) begin
            fixed_result[0] = set_q ^ ovf_cap_q;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            ctrl_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            set_q      <= 1'b0;
            ovf_cap_q  <= 1'b0;
            cout_cap_q <= 1'b0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src1_q     <= src1;
                        src2_q     <= src2;
                        ctrl_q     <= ALU_control;
                        result_q   <= '0;
                        idx_q      <= '0;
                        // Carry-in equals B_invert, turning A + ~B into A - B.
                        carry_q    <= ALU_control[2];
                        zero_q     <= 1'b0;
                        cout_q     <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    result_q[idx_q] <= res_bit;
                    carry_q         <= carry_out;
                    idx_q           <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        set_q      <= sum_bit;
                        // Signed overflow: carry into the MSB differs from carry out.
                        ovf_cap_q  <= carry_q ^ carry_out;
                        cout_cap_q <= carry_out;
                    end
                end
                S_FIX: begin
                    result_q   <= fixed_result;
                    zero_q     <= (fixed_result == '0);
                    cout_q     <= arith_op & cout_cap_q;
                    overflow_q <= arith_op & ovf_cap_q;
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_alu_slt.sv
module tb_serial_alu_slt;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] src1, src2;
    logic [3:0]   ALU_control;
    logic [W-1:0] result;
    logic         zero, cout, overflow, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_alu_slt #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural reference: whole-word arithmetic on the (optionally
    // inverted) operands, with B_invert acting as carry-in.
    task automatic ref_model(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] res, output logic z, output logic co, output logic ov);
        logic [W-1:0] aa, bb;
        logic [W:0]   sum;
        logic         sov;
        aa  = ctrl[3] ? ~a : a;
        bb  = ctrl[2] ? ~b : b;
        sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctrl[2]};
        sov = (aa[W-1] == bb[W-1]) && (sum[W-1] != aa[W-1]);
        case (ctrl[1:0])
            2'b00:   res = aa & bb;
            2'b01:   res = aa | bb;
            2'b10:   res = sum[W-1:0];
            default: res = (sum[W-1] ^ sov) ? W'(1) : W'(0);
        endcase
        z  = (res == '0);
        co = ctrl[1] ? sum[W] : 1'b0;
        ov = ctrl[1] ? sov : 1'b0;
    endtask

    // Runs one operation; glitch_cyc>0 pulses start again at that cycle.
    // Inputs are scrambled every cycle after acceptance.
    task automatic run_op(input string name, input logic [3:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int glitch_cyc);
        logic [W-1:0] er;
        logic         ez, ec, eo;
        int           cyc;
        ref_model(ctrl, a, b, er, ez, ec, eo);
        @(negedge clk);
        start = 1'b1; src1 = a; src2 = b; ALU_control = ctrl;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0; src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
        check_eq({name, "_busy"}, W'(busy), W'(1));
        while (!done && cyc < 3 * W) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
            start = (cyc == glitch_cyc) && !done;
        end
        start = 1'b0;
        $display("op %s ctrl=%b a=%h b=%h -> result=%h z=%b c=%b v=%b latency=%0d",
                 name, ctrl, a, b, result, zero, cout, overflow, cyc);
        check_eq({name, "_done"},    W'(done),     W'(1));
        check_eq({name, "_latency"}, W'(cyc),      W'(W + 2));
        check_eq({name, "_result"},  result,       er);
        check_eq({name, "_zero"},    W'(zero),     W'(ez));
        check_eq({name, "_cout"},    W'(cout),     W'(ec));
        check_eq({name, "_ovf"},     W'(overflow), W'(eo));
        check_eq({name, "_busy_dn"}, W'(busy),     W'(1));
        @(posedge clk);
        @(negedge clk);
        check_eq({name, "_done_1cy"}, W'(done), W'(0));
        check_eq({name, "_idle"},     W'(busy), W'(0));
        check_eq({name, "_hold"},     result,   er);
        if (glitch_cyc > 0) begin
            // A queued start would show up as a new busy period here.
            repeat (2) begin
                @(posedge clk);
                @(negedge clk);
                check_eq({name, "_no_restart"}, W'(busy | done), W'(0));
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           dones;

        rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; ALU_control = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_result", result, '0);
        check_eq("reset_flags", W'({zero, cout, overflow, busy, done}), W'(0));
        rst = 1'b0;

        // Directed cases
        run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 0);
        check_eq("add_ovf_lit", W'({result, overflow, cout, zero}),
                 W'({32'h80000000, 1'b1, 1'b0, 1'b0}));
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
        check_eq("sub_zero_lit", W'({result, zero, cout, overflow}), W'({32'h0, 1'b1, 1'b1, 1'b0}));
        run_op("slt_neg", 4'b0111, 32'hFFFFFFFD, 32'd2, 0);
        check_eq("slt_neg_lit", result, 32'h00000001);
        run_op("slt_ovf", 4'b0111, 32'h7FFFFFFF, 32'h80000000, 0);
        check_eq("slt_ovf_lit", result, 32'h00000000);
        run_op("and", 4'b0000, 32'h0F0F0F0F, 32'h00FF00FF, 0);
        check_eq("and_lit", W'({result, cout, overflow}), W'({32'h000F000F, 2'b00}));
        run_op("or", 4'b0001, 32'h0F0F0F0F, 32'h00FF00FF, 0);
        check_eq("or_lit", W'({result, cout, overflow}), W'({32'h0FFF0FFF, 2'b00}));
        run_op("nor", 4'b1100, 32'h0F0F0F0F, 32'h00FF00FF, 0);
        check_eq("nor_lit", W'({result, cout, overflow}), W'({32'hF000F000, 2'b00}));

        // start ignored while busy; next run_op starts in the cycle after done
        run_op("add_glitch", 4'b0010, 32'h12345678, 32'h11111111, 5);
        run_op("add_b2b", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 0);

        // Reset in the middle of an SLT
        @(negedge clk);
        start = 1'b1; src1 = 32'hFFFFFFFD; src2 = 32'd2; ALU_control = 4'b0111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_result", result, '0);
        check_eq("rst_mid_flags", W'({zero, cout, overflow, busy, done}), W'(0));
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("rst_no_done", W'(dones), W'(0));
        run_op("sub_after_rst", 4'b0110, 32'd9, 32'd4, 0);
        check_eq("sub_after_rst_lit", result, 32'd5);

        // Random operations, with equal operands mixed in for zero/SLT edges
        repeat (40) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_op("rand", 4'($urandom), ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
